debug_module_sysinfo: RTL

DEBUG_MODULE_SYSINFO -- requirements
Module: debug_module_sysinfo

---
 rtl/debug_module_sysinfo_pkg.sv | 33 +++
 rtl/debug_module_sysinfo_counter.sv | 48 ++++
 rtl/debug_module_sysinfo.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/debug_module_sysinfo_pkg.sv
// Shared definitions for the system-information debug slave: register
// offsets, CONTROL bit positions and the CONTROL readback helper.
package debug_module_sysinfo_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    // Word offsets of the Avalon-MM register map
    typedef enum logic [2:0] {
        REG_ID             = 3'd0,
        REG_TIMESTAMP      = 3'd1,
        REG_UPTIME_LO      = 3'd2,
        REG_UPTIME_HI_SNAP = 3'd3,
        REG_CTX_COUNT      = 3'd4,
        REG_SCRATCH        = 3'd5,
        REG_CONTROL        = 3'd6,
        REG_RESERVED       = 3'd7
    } reg_addr_e;

    // CONTROL bit positions
    localparam int unsigned CTRL_CLEAR_BIT  = 0;
    localparam int unsigned CTRL_FREEZE_BIT = 1;

    // CONTROL as seen by a reader: clear is a self-clearing strobe and always
    // reads 0, only freeze is stored, all upper bits read 0.
    function automatic logic [DATA_W-1:0] control_readback(input logic freeze);
        logic [DATA_W-1:0] value;
        value                  = 32'd0;
        value[CTRL_FREEZE_BIT] = freeze;
        return value;
    endfunction

endpackage

// File: rtl/debug_module_sysinfo_counter.sv
// Generic up-counter with enable, synchronous clear and selectable
// saturate/wrap behaviour at the all-ones value. Clear dominates enable.
module debug_module_sysinfo_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next-count selection: clear first, then enabled increment (held at max when saturating)
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = CNT_ZERO;
        end else if (en_i) begin
            if (SATURATE && (count_q == CNT_MAX)) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset to zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/debug_module_sysinfo.sv
// System-information Avalon-MM slave: fixed ID and build timestamp, a
// free-running uptime counter with a coherent high-word snapshot, an OS
// context-switch counter, a scratch register and a CONTROL register with
// clear and freeze bits. Reads have a fixed latency of one cycle.
module debug_module_sysinfo
    import debug_module_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSID_ID        = 32'h63B4_5A2E,
    parameter logic [31:0] SYSID_TIMESTAMP = 32'h0000_0000,
    parameter int unsigned UPTIME_W        = 48,
    parameter int unsigned CTX_SAT         = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    input  logic        ctx_switch
);

    // Decoded bus strobes; a write that collides with a read is dropped
    logic                wr_en_s;
    logic                clear_s;
    logic                uptime_en_s;

    // Counter outputs
    logic [UPTIME_W-1:0] uptime_s;
    logic [31:0]         ctx_count_s;
    logic [31:0]         hi_ext_s;

    // Architectural state
    logic [31:0]         readdata_d;
    logic [31:0]         readdata_q;
    logic                readdatavalid_d;
    logic                readdatavalid_q;
    logic [31:0]         snap_d;
    logic [31:0]         snap_q;
    logic [31:0]         scratch_d;
    logic [31:0]         scratch_q;
    logic                freeze_d;
    logic                freeze_q;

    assign wr_en_s     = write & ~read;
    assign clear_s     = wr_en_s & (address == REG_CONTROL) & writedata[CTRL_CLEAR_BIT];
    assign uptime_en_s = ~freeze_q;

    // Uptime counter: always wraps, stopped while frozen, zeroed by CONTROL.clear
    debug_module_sysinfo_counter #(
        .WIDTH    (UPTIME_W),
        .SATURATE (1'b0)
    ) u_uptime (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clr_i   (clear_s),
        .en_i    (uptime_en_s),
        .count_o (uptime_s)
    );

    // Context-switch counter: clear beats a coincident ctx_switch pulse
    debug_module_sysinfo_counter #(
        .WIDTH    (32),
        .SATURATE (CTX_SAT != 32'd0)
    ) u_ctx (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clr_i   (clear_s),
        .en_i    (ctx_switch),
        .count_o (ctx_count_s)
    );

    // Zero-extend the upper uptime bits to a full bus word
    always_comb begin
        hi_ext_s                 = 32'd0;
        hi_ext_s[UPTIME_W-33:0]  = uptime_s[UPTIME_W-1:32];
    end

    // Write decode for SCRATCH and CONTROL.freeze
    always_comb begin
        scratch_d = scratch_q;
        freeze_d  = freeze_q;
        if (wr_en_s) begin
            case (reg_addr_e'(address))
                REG_SCRATCH: scratch_d = writedata;
                REG_CONTROL: freeze_d  = writedata[CTRL_FREEZE_BIT];
                default: begin
                    scratch_d = scratch_q;
                    freeze_d  = freeze_q;
                end
            endcase
        end else begin
            scratch_d = scratch_q;
            freeze_d  = freeze_q;
        end
    end

    // High-word snapshot: captured by a UPTIME_LO read, zeroed by clear
    always_comb begin
        snap_d = snap_q;
        if (clear_s) begin
            snap_d = 32'd0;
        end else if (read && (address == REG_UPTIME_LO)) begin
            snap_d = hi_ext_s;
        end else begin
            snap_d = snap_q;
        end
    end

    // Read mux: sampled from current (pre-update) state; readdata holds when idle
    always_comb begin
        readdata_d      = readdata_q;
        readdatavalid_d = read;
        if (read) begin
            case (reg_addr_e'(address))
                REG_ID:             readdata_d = SYSID_ID;
                REG_TIMESTAMP:      readdata_d = SYSID_TIMESTAMP;
                REG_UPTIME_LO:      readdata_d = uptime_s[31:0];
                REG_UPTIME_HI_SNAP: readdata_d = snap_q;
                REG_CTX_COUNT:      readdata_d = ctx_count_s;
                REG_SCRATCH:        readdata_d = scratch_q;
                REG_CONTROL:        readdata_d = control_readback(freeze_q);
                REG_RESERVED:       readdata_d = 32'd0;
                default:            readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // State and response registers; reset drops any pending read response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q      <= 32'd0;
            readdatavalid_q <= 1'b0;
            snap_q          <= 32'd0;
            scratch_q       <= 32'd0;
            freeze_q        <= 1'b0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            snap_q          <= snap_d;
            scratch_q       <= scratch_d;
            freeze_q        <= freeze_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule
